// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared processor definitions for the instruction fetch stage: fetch FSM
// state encoding and instruction word geometry.
package imem_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StFault = 2'd2
  } fetch_state_e;

  localparam int unsigned InstrWidth = 32;
  localparam int unsigned InstrBytes = InstrWidth / 8;

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry {pc, instruction} buffer between fetch and decode. Flush wins over
// push/pop; a push is refused when full even if a pop happens the same cycle.
module fetch_skid_fifo #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 push_i,
  input  logic [AddrWidth-1:0] push_pc_i,
  input  logic [DataWidth-1:0] push_instr_i,
  input  logic                 pop_i,
  output logic [1:0]           count_o,
  output logic [AddrWidth-1:0] head_pc_o,
  output logic [DataWidth-1:0] head_instr_o
);

  logic [AddrWidth-1:0] pc_q    [2];
  logic [DataWidth-1:0] instr_q [2];
  logic                 wr_ptr_q, wr_ptr_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic [1:0]           count_q, count_d;
  logic                 do_push, do_pop;

  always_comb begin
    do_push  = push_i && (count_q != 2'd2) && !flush_i;
    do_pop   = pop_i && (count_q != 2'd0) && !flush_i;
    wr_ptr_d = wr_ptr_q ^ do_push;
    rd_ptr_d = rd_ptr_q ^ do_pop;
    count_d  = count_q + {1'b0, do_push} - {1'b0, do_pop};
    if (flush_i) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      pc_q[0]    <= '0;
      pc_q[1]    <= '0;
      instr_q[0] <= '0;
      instr_q[1] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) begin
        pc_q[wr_ptr_q]    <= push_pc_i;
        instr_q[wr_ptr_q] <= push_instr_i;
      end
    end
  end

  assign count_o      = count_q;
  assign head_pc_o    = pc_q[rd_ptr_q];
  assign head_instr_o = instr_q[rd_ptr_q];

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: walks the PC through a combinational-read
// instruction memory, buffers words for decode and faults on out-of-range PCs.
module imem_fetch_ctrl
  import imem_fetch_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = InstrWidth,
  parameter int unsigned MEM_BYTES  = 24,
  parameter int unsigned RESET_PC   = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic                  redirect_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  input  logic [DATA_WIDTH-1:0] imem_rd_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_instr_o,
  output logic [ADDR_WIDTH-1:0] out_pc_o,
  output logic                  fault_o,
  output logic [ADDR_WIDTH-1:0] fault_addr_o
);

  localparam logic [ADDR_WIDTH:0] MemEnd  = (ADDR_WIDTH+1)'(MEM_BYTES);
  localparam logic [ADDR_WIDTH:0] WordInc = (ADDR_WIDTH+1)'(InstrBytes);

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] fault_addr_q, fault_addr_d;
  logic [1:0]            count;
  logic                  push, pop, flush;
  logic [ADDR_WIDTH:0]   pc_end;
  logic                  fetch_ok;

  // One extra bit so a PC near the top of the address space cannot wrap into range.
  assign pc_end   = {1'b0, pc_q} + WordInc;
  assign fetch_ok = (pc_end <= MemEnd);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fault_addr_d = fault_addr_q;
    push         = 1'b0;
    flush        = 1'b0;
    pop          = (count != 2'd0) && out_ready_i;
    if (redirect_i) begin
      flush = 1'b1;
      pop   = 1'b0;
      if (redirect_pc_i[1:0] != 2'b00) begin
        state_d      = StFault;
        fault_addr_d = redirect_pc_i;
      end else begin
        pc_d    = redirect_pc_i;
        state_d = en_i ? StRun : StIdle;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (en_i) state_d = StRun;
        end
        StRun: begin
          if (!en_i) begin
            state_d = StIdle;
          end else if (!fetch_ok) begin
            state_d      = StFault;
            fault_addr_d = pc_q;
          end else if (count != 2'd2) begin
            push = 1'b1;
            pc_d = pc_end[ADDR_WIDTH-1:0];
          end
        end
        StFault: ;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      pc_q         <= ADDR_WIDTH'(RESET_PC);
      fault_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  fetch_skid_fifo #(
    .AddrWidth(ADDR_WIDTH),
    .DataWidth(DATA_WIDTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush),
    .push_i      (push),
    .push_pc_i   (pc_q),
    .push_instr_i(imem_rd_i),
    .pop_i       (pop),
    .count_o     (count),
    .head_pc_o   (out_pc_o),
    .head_instr_o(out_instr_o)
  );

  assign imem_addr_o  = pc_q;
  assign out_valid_o  = (count != 2'd0);
  assign fault_o      = (state_q == StFault);
  assign fault_addr_o = fault_addr_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl: directed scenarios plus random
// traffic compared against a queue-based reference model.
module tb_imem_fetch_ctrl;

  localparam int unsigned MemBytes = 24;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_ready = 1'b0;
  logic [31:0] imem_addr, imem_rd, out_instr, out_pc, fault_addr;
  logic        out_valid, fault;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  // Reference model: 0 idle, 1 fetching, 2 faulted.
  int          m_mode;
  logic [31:0] m_pc;
  logic [31:0] m_fault_addr;
  entry_t      m_q[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (longint'(a) + 4 <= longint'(MemBytes)) return {8'hA0, a[7:0], 8'h5C, ~a[7:0]};
    return 32'hDEAD_BEEF;
  endfunction

  assign imem_rd = mem_word(imem_addr);

  imem_fetch_ctrl #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .MEM_BYTES (MemBytes),
    .RESET_PC  (0)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .en_i         (en),
    .redirect_i   (redirect),
    .redirect_pc_i(redirect_pc),
    .imem_addr_o  (imem_addr),
    .imem_rd_i    (imem_rd),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_instr_o  (out_instr),
    .out_pc_o     (out_pc),
    .fault_o      (fault),
    .fault_addr_o (fault_addr)
  );

  function automatic void model_reset();
    m_mode = 0;
    m_pc = 32'd0;
    m_fault_addr = 32'd0;
    m_q.delete();
  endfunction

  function automatic void model_step();
    bit was_full = (m_q.size() == 2);
    bit popping  = (m_q.size() != 0) && out_ready;
    entry_t e;
    if (redirect) begin
      m_q.delete();
      if (redirect_pc[1:0] != 2'b00) begin
        m_mode = 2;
        m_fault_addr = redirect_pc;
      end else begin
        m_pc = redirect_pc;
        m_mode = en ? 1 : 0;
      end
      return;
    end
    if (m_mode == 0) begin
      if (en) m_mode = 1;
    end else if (m_mode == 1) begin
      if (!en) m_mode = 0;
      else if (longint'(m_pc) + 4 > longint'(MemBytes)) begin
        m_mode = 2;
        m_fault_addr = m_pc;
      end else if (!was_full) begin
        e.pc = m_pc;
        e.instr = mem_word(m_pc);
        m_q.push_back(e);
        m_pc = m_pc + 4;
      end
    end
    if (popping) void'(m_q.pop_front());
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    en = 1'b0;
    redirect = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    #1;
    n_cmp += 6;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0b want 0", out_valid); end
    if (fault !== 1'b0) begin n_err++; $display("FAIL reset_fault got %0b want 0", fault); end
    if (fault_addr !== 32'd0) begin n_err++; $display("FAIL reset_fault_addr got %0h want 0", fault_addr); end
    if (imem_addr !== 32'd0) begin n_err++; $display("FAIL reset_imem_addr got %0h want 0", imem_addr); end
    if (out_pc !== 32'd0) begin n_err++; $display("FAIL reset_out_pc got %0h want 0", out_pc); end
    if (out_instr !== 32'd0) begin n_err++; $display("FAIL reset_out_instr got %0h want 0", out_instr); end
  endtask

  task automatic test_full_run();
    int got = 0;
    do_reset();
    en = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && got < 6; i++) begin
      if (out_valid) begin
        n_cmp += 2;
        if (out_pc !== 32'(got * 4)) begin
          n_err++; $display("FAIL run_pc got %0h want %0h", out_pc, got * 4);
        end
        if (out_instr !== mem_word(32'(got * 4))) begin
          n_err++; $display("FAIL run_instr got %0h want %0h", out_instr, mem_word(32'(got * 4)));
        end
        got++;
      end
      tick();
    end
    n_cmp += 4;
    if (got != 6) begin n_err++; $display("FAIL run_count got %0d want 6", got); end
    if (fault !== 1'b1) begin n_err++; $display("FAIL run_fault got %0b want 1", fault); end
    if (fault_addr !== 32'd24) begin n_err++; $display("FAIL run_fault_addr got %0h want 18", fault_addr); end
    tick();
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL run_drained got %0b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    int got = 0;
    do_reset();
    en = 1'b1;
    out_ready = 1'b0;
    repeat (5) tick();
    n_cmp += 3;
    if (imem_addr !== 32'd8) begin n_err++; $display("FAIL bp_imem_addr got %0h want 8", imem_addr); end
    if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid got %0b want 1", out_valid); end
    if (out_pc !== 32'd0) begin n_err++; $display("FAIL bp_head got %0h want 0", out_pc); end
    out_ready = 1'b1;
    for (int i = 0; i < 10 && got < 3; i++) begin
      if (out_valid) begin
        n_cmp++;
        if (out_pc !== 32'(got * 4)) begin
          n_err++; $display("FAIL bp_order got %0h want %0h", out_pc, got * 4);
        end
        got++;
      end
      tick();
    end
    n_cmp++;
    if (got != 3) begin n_err++; $display("FAIL bp_count got %0d want 3", got); end
  endtask

  task automatic test_redirect_full();
    do_reset();
    en = 1'b1;
    out_ready = 1'b0;
    repeat (4) tick();
    redirect = 1'b1;
    redirect_pc = 32'd12;
    tick();
    redirect = 1'b0;
    n_cmp += 3;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL redir_flush got %0b want 0", out_valid); end
    out_ready = 1'b1;
    tick();
    if (!(out_valid === 1'b1 && out_pc === 32'd12)) begin
      n_err++; $display("FAIL redir_first got v=%0b pc=%0h want v=1 pc=c", out_valid, out_pc);
    end
    tick();
    if (!(out_valid === 1'b1 && out_pc === 32'd16)) begin
      n_err++; $display("FAIL redir_second got v=%0b pc=%0h want v=1 pc=10", out_valid, out_pc);
    end
  endtask

  task automatic wait_fault(input string tag);
    for (int i = 0; i < 30 && fault !== 1'b1; i++) tick();
    n_cmp++;
    if (fault !== 1'b1) begin n_err++; $display("FAIL %s_timeout got fault=%0b want 1", tag, fault); end
  endtask

  task automatic test_fault_redirect();
    do_reset();
    en = 1'b1;
    out_ready = 1'b1;
    wait_fault("fr1");
    redirect = 1'b1;
    redirect_pc = 32'd4;
    tick();
    redirect = 1'b0;
    n_cmp += 2;
    if (fault !== 1'b0) begin n_err++; $display("FAIL fr_exit got %0b want 0", fault); end
    tick();
    if (!(out_valid === 1'b1 && out_pc === 32'd4)) begin
      n_err++; $display("FAIL fr_restart got v=%0b pc=%0h want v=1 pc=4", out_valid, out_pc);
    end
    wait_fault("fr2");
    redirect = 1'b1;
    redirect_pc = 32'd6;
    tick();
    redirect = 1'b0;
    n_cmp += 2;
    if (fault !== 1'b1) begin n_err++; $display("FAIL fr_misalign got %0b want 1", fault); end
    if (fault_addr !== 32'd6) begin n_err++; $display("FAIL fr_misalign_addr got %0h want 6", fault_addr); end
  endtask

  task automatic test_async_reset();
    do_reset();
    en = 1'b1;
    out_ready = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    n_cmp += 3;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL ar_valid got %0b want 0", out_valid); end
    if (imem_addr !== 32'd0) begin n_err++; $display("FAIL ar_pc got %0h want 0", imem_addr); end
    model_reset();
    #3;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (2) tick();
    if (!(out_valid === 1'b1 && out_pc === 32'd0)) begin
      n_err++; $display("FAIL ar_restart got v=%0b pc=%0h want v=1 pc=0", out_valid, out_pc);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      en = ($urandom_range(0, 9) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      redirect = ($urandom_range(0, 19) == 0);
      redirect_pc = 32'($urandom_range(0, 31));
      if ($urandom_range(0, 3) != 0) redirect_pc[1:0] = 2'b00;
      tick();
      n_cmp += 4;
      if (out_valid !== (m_q.size() != 0)) begin
        n_err++; $display("FAIL rnd_valid cyc %0d got %0b want %0b", i, out_valid, m_q.size() != 0);
      end
      if (fault !== (m_mode == 2)) begin
        n_err++; $display("FAIL rnd_fault cyc %0d got %0b want %0b", i, fault, m_mode == 2);
      end
      if (fault_addr !== m_fault_addr) begin
        n_err++; $display("FAIL rnd_fault_addr cyc %0d got %0h want %0h", i, fault_addr, m_fault_addr);
      end
      if (imem_addr !== m_pc) begin
        n_err++; $display("FAIL rnd_pc cyc %0d got %0h want %0h", i, imem_addr, m_pc);
      end
      if (m_q.size() != 0) begin
        n_cmp += 2;
        if (out_pc !== m_q[0].pc) begin
          n_err++; $display("FAIL rnd_out_pc cyc %0d got %0h want %0h", i, out_pc, m_q[0].pc);
        end
        if (out_instr !== m_q[0].instr) begin
          n_err++; $display("FAIL rnd_instr cyc %0d got %0h want %0h", i, out_instr, m_q[0].instr);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_full_run();
    test_backpressure();
    test_redirect_full();
    test_fault_redirect();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/imem_fetch_ctrl.md
IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, SHALL set the width of the PC and all address ports.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the instruction word width (4 bytes, little-endian from the memory).
REQ-003 Parameter MEM_BYTES, default 24, SHALL set the instruction memory size in bytes; legal fetch iff PC+4 <= MEM_BYTES.
REQ-004 Parameter RESET_PC, default 0, SHALL set the PC value loaded at reset.
REQ-005 CLK  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 RST_N  in  1  SHALL be the asynchronous, active-low reset.
REQ-007 EN  in  1  SHALL be the fetch enable.
REQ-008 REDIRECT  in  1 and REDIRECT_PC  in  ADDR_WIDTH SHALL carry the branch/jump redirect request and target.
REQ-009 IMEM_ADDR  out  ADDR_WIDTH SHALL drive the combinational-read instruction memory address (equals PC).
REQ-010 IMEM_RD  in  DATA_WIDTH SHALL be the same-cycle read data for IMEM_ADDR.
REQ-011 OUT_VALID  out  1, OUT_READY  in  1, OUT_INSTR  out  DATA_WIDTH, OUT_PC  out  ADDR_WIDTH SHALL form the valid/ready instruction stream to decode.
REQ-012 FAULT  out  1 and FAULT_ADDR  out  ADDR_WIDTH SHALL report a fetch fault and the offending address.

Function
REQ-013 States SHALL be IDLE, RUN, FAULT; FAULT SHALL equal (state==FAULT).
REQ-014 IDLE -> RUN on a clock edge with EN=1; RUN -> IDLE on an edge with EN=0; no fetches in IDLE.
REQ-015 A 2-entry FIFO of {PC, instruction} SHALL buffer fetched words; OUT_VALID = (count!=0); OUT_INSTR/OUT_PC = head entry.
REQ-016 In RUN with REDIRECT=0, count<2, and PC+4<=MEM_BYTES, a fetch SHALL push {PC, IMEM_RD} and set PC <= PC+4.
REQ-017 In RUN with REDIRECT=0 and PC+4>MEM_BYTES, no push SHALL occur; next state FAULT, FAULT_ADDR <= PC; range compare in ADDR_WIDTH+1 bits (no wrap-around).
REQ-018 A pop SHALL occur on any edge with OUT_VALID=1 and OUT_READY=1, in any state.
REQ-019 Simultaneous push and pop SHALL leave count unchanged and preserve order; at count=2 no push occurs even if a pop occurs the same cycle.
REQ-020 REDIRECT=1 SHALL take priority over push/pop/fault: FIFO flushed (count 0 next cycle), PC <= REDIRECT_PC, next state RUN if EN=1 else IDLE; it is accepted in all states including FAULT.
REQ-021 REDIRECT_PC[1:0] != 0 SHALL instead flush, enter FAULT, FAULT_ADDR <= REDIRECT_PC.
REQ-022 In FAULT the FIFO SHALL continue to drain; only REDIRECT exits FAULT.
REQ-023 Latency: EN rising in IDLE -> first push one cycle later -> OUT_VALID high the following cycle (2 edges).
REQ-024 EN=0 in RUN SHALL stop fetching but retain FIFO contents and PC.

Reset
REQ-025 RST_N=0 SHALL asynchronously set state=IDLE, PC=RESET_PC, count=0, FIFO pointers=0, FAULT_ADDR=0.
REQ-026 Reset outputs: OUT_VALID=0, FAULT=0, FAULT_ADDR=0, IMEM_ADDR=RESET_PC; OUT_INSTR/OUT_PC SHALL be 0 (FIFO storage cleared).
REQ-027 Reset mid-operation SHALL discard all buffered entries; first fetch after release from RESET_PC.

Structure
REQ-028 State encoding (IDLE/RUN/FAULT) and the instruction word width constant SHALL live in the shared processor package.
REQ-029 The 2-entry FIFO SHALL be one sub-module, fetch_skid_fifo, with push/pop/flush and count outputs.

Verification
REQ-030 MEM_BYTES=24, EN=1, OUT_READY=1 from reset: six instructions at PC 0,4,...,20 in order, then FAULT=1, FAULT_ADDR=24.
REQ-031 OUT_READY=0 for 5 cycles after start: count saturates at 2, PC=8, IMEM_ADDR held; on release PCs 0,4,8 emerge with no loss or duplication.
REQ-032 REDIRECT=1, REDIRECT_PC=12 while count=2: next cycle OUT_VALID=0, then OUT_PC=12, 16 follow.
REQ-033 In FAULT, REDIRECT_PC=4: FAULT=0 next cycle, OUT_PC=4 two edges later; REDIRECT_PC=6: FAULT stays 1, FAULT_ADDR=6.
REQ-034 RST_N low for half a cycle mid-stream with count=2: OUT_VALID=0 immediately, after release fetch restarts at PC 0.
